// File: rtl/cancel_pkg.sv
// Shared constants and types for the per-client cancelled-order accumulator.
package cancel_pkg;

  localparam int unsigned D_WIDTH = 32;
  localparam int unsigned A_WIDTH = 5;
  localparam int unsigned A_MAX   = 1 << A_WIDTH;

  localparam logic [D_WIDTH-1:0] THRESHOLD = 32'd1_000_000;

  typedef logic [A_WIDTH-1:0] client_id_t;
  typedef logic [D_WIDTH-1:0] value_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder: clamps to all-ones when the sum carries out.
module sat_add
  import cancel_pkg::*;
(
  input  logic [D_WIDTH-1:0] a_i,
  input  logic [D_WIDTH-1:0] b_i,
  output logic [D_WIDTH-1:0] sum_o
);

  logic [D_WIDTH:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o    = full_sum[D_WIDTH] ? '1 : full_sum[D_WIDTH-1:0];

endmodule

// File: rtl/cancel_accumulator.sv
// Read-modify-write stage for the per-client cancelled-order RAM: zero sweep
// after reset, then one saturating accumulate per cycle with W/W2 forwarding.
module cancel_accumulator
  import cancel_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  // in_valid/in_ready: an event transfers on every cycle where both are high;
  // in_ready is low for the whole zero sweep and constantly high afterwards.
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] in_client_id,
  input  logic [D_WIDTH-1:0] in_value,
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read,
  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic               ram_write_enable,
  output logic               alert_valid,
  output logic [A_WIDTH-1:0] alert_client_id,
  output logic [D_WIDTH-1:0] alert_total,
  output logic               init_done,
  output state_t             dbg_state_o
);

  localparam logic [A_WIDTH:0] INIT_END = (A_WIDTH + 1)'(A_MAX);

  state_t             state_q;
  logic [A_WIDTH:0]   init_cnt_q;
  logic               in_ready_q;
  logic               init_done_q;

  logic               s1_valid_q;
  logic [A_WIDTH-1:0] s1_client_q;
  logic [D_WIDTH-1:0] s1_value_q;

  // W stage doubles as the RAM write port registers.
  logic               w_valid_q;
  logic               ram_we_q;
  logic [A_WIDTH-1:0] ram_addr_q;
  logic [D_WIDTH-1:0] ram_data_q;

  logic               w2_valid_q;
  logic [A_WIDTH-1:0] w2_client_q;
  logic [D_WIDTH-1:0] w2_data_q;

  logic               alert_valid_q;
  logic [A_WIDTH-1:0] alert_client_q;
  logic [D_WIDTH-1:0] alert_total_q;

  logic [D_WIDTH-1:0] old_d;
  logic [D_WIDTH-1:0] new_d;
  logic               crosses_d;

  // The RAM returns old data on read-during-write, so the two most recent
  // writes must override it; the newer one wins.
  always_comb begin
    old_d = ram_data_read;
    if (w_valid_q && (ram_addr_q == s1_client_q)) begin
      old_d = ram_data_q;
    end else if (w2_valid_q && (w2_client_q == s1_client_q)) begin
      old_d = w2_data_q;
    end
  end

  sat_add u_sat_add (
    .a_i   (old_d),
    .b_i   (s1_value_q),
    .sum_o (new_d)
  );

  assign crosses_d = (old_d < THRESHOLD) && (new_d >= THRESHOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= INIT;
      init_cnt_q     <= '0;
      in_ready_q     <= 1'b0;
      init_done_q    <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_client_q    <= '0;
      s1_value_q     <= '0;
      w_valid_q      <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_data_q     <= '0;
      w2_valid_q     <= 1'b0;
      w2_client_q    <= '0;
      w2_data_q      <= '0;
      alert_valid_q  <= 1'b0;
      alert_client_q <= '0;
      alert_total_q  <= '0;
    end else begin
      s1_valid_q    <= in_valid && in_ready_q;
      s1_client_q   <= in_client_id;
      s1_value_q    <= in_value;
      w2_valid_q    <= w_valid_q;
      w2_client_q   <= ram_addr_q;
      w2_data_q     <= ram_data_q;
      alert_valid_q <= 1'b0;
      case (state_q)
        INIT: begin
          w_valid_q <= 1'b0;
          if (init_cnt_q == INIT_END) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
            in_ready_q  <= 1'b1;
            ram_we_q    <= 1'b0;
          end else begin
            ram_we_q   <= 1'b1;
            ram_addr_q <= init_cnt_q[A_WIDTH-1:0];
            ram_data_q <= '0;
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        RUN: begin
          w_valid_q <= s1_valid_q;
          ram_we_q  <= s1_valid_q;
          if (s1_valid_q) begin
            ram_addr_q <= s1_client_q;
            ram_data_q <= new_d;
            if (crosses_d) begin
              alert_valid_q  <= 1'b1;
              alert_client_q <= s1_client_q;
              alert_total_q  <= new_d;
            end
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign in_ready          = in_ready_q;
  assign init_done         = init_done_q;
  assign ram_address_read  = in_client_id;
  assign ram_address_write = ram_addr_q;
  assign ram_data_write    = ram_data_q;
  assign ram_write_enable  = ram_we_q;
  assign alert_valid       = alert_valid_q;
  assign alert_client_id   = alert_client_q;
  assign alert_total       = alert_total_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_cancel_accumulator.sv
// Bench for cancel_accumulator: behavioural RAM, per-client total model and
// a cycle-stamped expected-write queue.
module tb_cancel_accumulator;
  import cancel_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [A_WIDTH-1:0] in_client_id = '0;
  logic [D_WIDTH-1:0] in_value = '0;
  logic [A_WIDTH-1:0] ram_address_read;
  logic [D_WIDTH-1:0] ram_data_read = '0;
  logic [A_WIDTH-1:0] ram_address_write;
  logic [D_WIDTH-1:0] ram_data_write;
  logic               ram_write_enable;
  logic               alert_valid;
  logic [A_WIDTH-1:0] alert_client_id;
  logic [D_WIDTH-1:0] alert_total;
  logic               init_done;
  state_t             dbg_state_o;

  cancel_accumulator dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_client_id      (in_client_id),
    .in_value          (in_value),
    .ram_address_read  (ram_address_read),
    .ram_data_read     (ram_data_read),
    .ram_address_write (ram_address_write),
    .ram_data_write    (ram_data_write),
    .ram_write_enable  (ram_write_enable),
    .alert_valid       (alert_valid),
    .alert_client_id   (alert_client_id),
    .alert_total       (alert_total),
    .init_done         (init_done),
    .dbg_state_o       (dbg_state_o)
  );

  // ---------------- clock / cycle counter / external RAM ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [D_WIDTH-1:0] mem [A_MAX];
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address_write] <= ram_data_write;
    ram_data_read <= mem[ram_address_read];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int                 cyc;
    logic [A_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0] data;
    logic               alert;
  } exp_t;

  exp_t exp_q[$];
  longint unsigned tot [A_MAX];
  int  done_cyc   = 0;
  bit  rst_active = 1'b1;
  int  checks     = 0;
  int  errors     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (rst_active) return;
    check_eq("init_done", {63'd0, init_done}, {63'd0, cyc >= done_cyc});
    check_eq("in_ready", {63'd0, in_ready}, {63'd0, cyc >= done_cyc});
    check_eq("state", {63'd0, dbg_state_o == RUN}, {63'd0, cyc >= done_cyc});
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check_eq("we", {63'd0, ram_write_enable}, 64'd1);
      check_eq("waddr", {59'd0, ram_address_write}, {59'd0, e.addr});
      check_eq("wdata", {32'd0, ram_data_write}, {32'd0, e.data});
      check_eq("alert", {63'd0, alert_valid}, {63'd0, e.alert});
      if (e.alert) begin
        check_eq("alert_id", {59'd0, alert_client_id}, {59'd0, e.addr});
        check_eq("alert_total", {32'd0, alert_total}, {32'd0, e.data});
      end
    end else begin
      check_eq("we_idle", {63'd0, ram_write_enable}, 64'd0);
      check_eq("alert_idle", {63'd0, alert_valid}, 64'd0);
    end
  endtask

  // Reference: serial per-client totals, clamped at 2^32-1; alert on crossing.
  task automatic model_accept(input logic [A_WIDTH-1:0] id, input logic [D_WIDTH-1:0] val);
    exp_t e;
    longint unsigned old_t, new_t;
    old_t = tot[id];
    new_t = old_t + val;
    if (new_t > 64'hFFFF_FFFF) new_t = 64'hFFFF_FFFF;
    tot[id] = new_t;
    e.cyc   = cyc + 2;
    e.addr  = id;
    e.data  = new_t[31:0];
    e.alert = (old_t < 1_000_000) && (new_t >= 1_000_000);
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic v, input logic [A_WIDTH-1:0] id, input logic [D_WIDTH-1:0] val);
    @(negedge clk);
    monitor();
    in_valid     = v;
    in_client_id = id;
    in_value     = val;
    if (v && (cyc >= done_cyc)) model_accept(id, val);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, '0);
  endtask

  task automatic apply_reset(input int n);
    exp_t e;
    @(negedge clk);
    monitor();
    reset      = 1'b1;
    in_valid   = 1'b0;
    rst_active = 1'b1;
    exp_q.delete();
    repeat (n) begin
      @(negedge clk);
      check_eq("rst_we", {63'd0, ram_write_enable}, 64'd0);
      check_eq("rst_ready", {63'd0, in_ready}, 64'd0);
      check_eq("rst_done", {63'd0, init_done}, 64'd0);
      check_eq("rst_alert", {63'd0, alert_valid}, 64'd0);
      check_eq("rst_waddr", {59'd0, ram_address_write}, 64'd0);
      check_eq("rst_wdata", {32'd0, ram_data_write}, 64'd0);
      check_eq("rst_alert_id", {59'd0, alert_client_id}, 64'd0);
      check_eq("rst_alert_total", {32'd0, alert_total}, 64'd0);
    end
    reset      = 1'b0;
    rst_active = 1'b0;
    done_cyc   = cyc + 1 + A_MAX;
    for (int k = 0; k < A_MAX; k++) begin
      e.cyc   = cyc + 1 + k;
      e.addr  = k[A_WIDTH-1:0];
      e.data  = '0;
      e.alert = 1'b0;
      exp_q.push_back(e);
      tot[k]  = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    apply_reset(3);
    idle(40);

    tick(1, 5'd3, 32'd100);
    idle(1);
    tick(1, 5'd3, 32'd50);
    idle(4);
    check_eq("ram3", {32'd0, mem[3]}, 64'd150);

    for (int i = 1; i <= 4; i++) tick(1, 5'd7, i);
    idle(3);

    for (int i = 0; i < 4; i++) tick(1, (i % 2 == 0) ? 5'd1 : 5'd2, 32'd10);
    idle(3);

    tick(1, 5'd5, 32'd999_999);
    tick(1, 5'd5, 32'd1);
    tick(1, 5'd5, 32'd5);
    idle(3);

    tick(1, 5'd9, 32'hFFFF_FFF0);
    tick(1, 5'd9, 32'h20);
    tick(1, 5'd9, 32'h1);
    idle(3);
    check_eq("ram9_sat", {32'd0, mem[9]}, 64'hFFFF_FFFF);

    for (int i = 0; i < 400; i++) begin
      logic [A_WIDTH-1:0] id;
      logic [D_WIDTH-1:0] val;
      int r;
      id = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      r  = $urandom_range(0, 19);
      if (r == 0)      val = $urandom;
      else if (r < 6)  val = $urandom_range(0, 400_000);
      else             val = $urandom_range(0, 1000);
      tick($urandom_range(0, 9) < 8, id, val);
    end

    tick(1, 5'd3, 32'd7);
    tick(1, 5'd9, 32'd7);
    apply_reset(2);
    idle(40);
    check_eq("ram3_rezero", {32'd0, mem[3]}, 64'd0);
    check_eq("ram9_rezero", {32'd0, mem[9]}, 64'd0);

    tick(1, 5'd9, 32'd1_000_000);
    idle(4);
    check_eq("ram9_after", {32'd0, mem[9]}, 64'd1_000_000);
    check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
